// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array front-end.
// The feeder FSM walks LOAD -> CLEAR -> STREAM -> DONE and back to LOAD.
package systolic_pkg;

  typedef enum logic [1:0] {LOAD, CLEAR, STREAM, DONE} feeder_state_t;

  localparam int DEFAULT_DIM = 4;

  // Skewed wavefront plus flush: the last operand pair enters at 2*DIM-2 and
  // needs DIM more hops to reach the far corner node.
  function automatic int stream_len(input int dim);
    return 3 * dim - 1;
  endfunction

  localparam int STREAM_LEN = stream_len(DEFAULT_DIM);

endpackage

// File: rtl/skew_lane.sv
// One edge lane of the skewed operand wavefront: presents element (t - LANE)
// of its buffered row/column while t is inside the lane's window, else zero.
module skew_lane
  import systolic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIM   = DEFAULT_DIM,
  parameter int LANE  = 0,
  localparam int TW   = $clog2(3 * DIM)
) (
  input  logic [WIDTH-1:0] lane_data [DIM],
  input  logic [TW-1:0]    t,
  output logic [WIDTH-1:0] lane_out
);

  // Window compare on unsigned t avoids any signed subtraction.
  always_comb begin
    lane_out = '0;
    if (t >= TW'(LANE) && t < TW'(LANE + DIM)) begin
      for (int k = 0; k < DIM; k++) begin
        if (t == TW'(LANE + k)) lane_out = lane_data[k];
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Producer side of the systolic array operand interface: loads an A/B pair,
// clears the array, streams the skewed wavefront, then holds done until acked.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIM   = DEFAULT_DIM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_col [DIM],
  input  logic [WIDTH-1:0] b_row [DIM],
  output logic             arr_clr,
  output logic [WIDTH-1:0] A_in  [DIM],
  output logic [WIDTH-1:0] B_in  [DIM],
  output logic             busy,
  output logic             done,
  input  logic             done_ack
);

  localparam int TW = $clog2(3 * DIM);
  localparam int LW = $clog2(DIM + 1);
  localparam logic [TW-1:0] T_LAST  = TW'(stream_len(DIM) - 1);
  localparam logic [LW-1:0] LD_LAST = LW'(DIM - 1);

  feeder_state_t    state;
  logic [TW-1:0]    t;
  logic [LW-1:0]    ld_cnt;

  // a_buf[i][k] = A[i][k]; b_buf is stored transposed, b_buf[j][k] = B[k][j],
  // so each lane sees its own contiguous row of elements.
  logic [WIDTH-1:0] a_buf [DIM][DIM];
  logic [WIDTH-1:0] b_buf [DIM][DIM];
  logic [WIDTH-1:0] a_sel [DIM];
  logic [WIDTH-1:0] b_sel [DIM];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= LOAD;
      t      <= '0;
      ld_cnt <= '0;
      for (int i = 0; i < DIM; i++) begin
        for (int k = 0; k < DIM; k++) begin
          a_buf[i][k] <= '0;
          b_buf[i][k] <= '0;
        end
      end
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            for (int k = 0; k < DIM; k++) begin
              if (ld_cnt == LW'(k)) begin
                for (int i = 0; i < DIM; i++) begin
                  a_buf[i][k] <= a_col[i];
                  b_buf[i][k] <= b_row[i];
                end
              end
            end
            ld_cnt <= ld_cnt + LW'(1);
            if (ld_cnt == LD_LAST) state <= CLEAR;
          end
        end
        CLEAR: begin
          t     <= '0;
          state <= STREAM;
        end
        STREAM: begin
          if (t == T_LAST) state <= DONE;
          else             t     <= t + TW'(1);
        end
        DONE: begin
          if (done_ack) begin
            ld_cnt <= '0;
            state  <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign in_ready = (state == LOAD);
  assign arr_clr  = (state == CLEAR);
  assign busy     = (state == CLEAR) || (state == STREAM);
  assign done     = (state == DONE);

  for (genvar i = 0; i < DIM; i++) begin : g_a_lane
    skew_lane #(.WIDTH(WIDTH), .DIM(DIM), .LANE(i)) u_lane (
      .lane_data (a_buf[i]),
      .t         (t),
      .lane_out  (a_sel[i])
    );
    assign A_in[i] = (state == STREAM) ? a_sel[i] : '0;
  end

  for (genvar j = 0; j < DIM; j++) begin : g_b_lane
    skew_lane #(.WIDTH(WIDTH), .DIM(DIM), .LANE(j)) u_lane (
      .lane_data (b_buf[j]),
      .t         (t),
      .lane_out  (b_sel[j])
    );
    assign B_in[j] = (state == STREAM) ? b_sel[j] : '0;
  end

endmodule
